// File: rtl/nn_input_loader.sv
// Input loader for the first linear layer: collects N_IN signed activations,
// fires layer_start and holds the vector until layer_done. Optional macro NN_INPUT_CLAMP_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_LOAD | accepting activations into slot idx
// ST_FIRE | one-cycle layer_start pulse, vector frozen
// ST_WAIT | vector frozen until the layer reports done
module nn_input_loader #(
    parameter int N_IN = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 flush,
    output logic [N_IN*DW-1:0]   vec_out,
    output logic                 layer_start,
    input  logic                 layer_done,
    output logic                 busy,
    output logic [7:0]           sample_cnt
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [DW-1:0] word_in;
    logic          accept;
    logic          last_word;

`ifdef NN_INPUT_CLAMP_EN
    // Keep activations symmetric (+/-(2^(DW-1)-1)) to match the quantized weight range.
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    assign word_in = (in_data == MOST_NEG) ? (MOST_NEG + 1'b1) : in_data;
`else
    assign word_in = in_data;
`endif

    assign accept    = (state == ST_LOAD) && in_valid && in_ready && !flush;
    assign last_word = accept && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (last_word) state_nxt = ST_FIRE;
            ST_FIRE: state_nxt = ST_WAIT;
            ST_WAIT: if (layer_done) state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
        if (flush) begin
            state_nxt = ST_LOAD;
        end
    end

    always_comb begin
        layer_start = (state == ST_FIRE);
        busy        = (state == ST_FIRE) || (state == ST_WAIT);
    end

    // in_ready is registered from the next state so it drops right after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (accept) begin
            idx <= last_word ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_IN; k++) begin
                if (idx == IW'(k)) begin
                    vec_out[k*DW +: DW] <= word_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if ((state == ST_WAIT) && layer_done && !flush) begin
            sample_cnt <= sample_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_nn_input_loader.sv
// Directed bench for nn_input_loader (N_IN=4, DW=8); expected values hand-computed.
module tb_nn_input_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        flush;
    logic [31:0] vec_out;
    logic        layer_start;
    logic        layer_done;
    logic        busy;
    logic [7:0]  sample_cnt;

    int n_cmp;
    int n_fail;

`ifdef NN_INPUT_CLAMP_EN
    localparam logic [7:0] NEG_EXP = 8'h81;
`else
    localparam logic [7:0] NEG_EXP = 8'h80;
`endif

    nn_input_loader #(.N_IN(4), .DW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .vec_out     (vec_out),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .busy        (busy),
        .sample_cnt  (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic run_sample(input logic [7:0] base);
        for (int w = 0; w < 4; w++) begin
            send_word(base + 8'(w));
        end
        in_valid = 1'b0;
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        flush = 1'b0;
        layer_done = 1'b0;

        // reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_vec", vec_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(layer_start), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        #10 rst_n = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // basic back-to-back load
        send_word(8'd5);
        send_word(8'hFD);
        send_word(8'd127);
        chk("basic_ready_w2", 32'(in_ready), 32'd1);
        chk("basic_start_w2", 32'(layer_start), 32'd0);
        send_word(8'd0);
        in_valid = 1'b0;
        chk("basic_ready_drop", 32'(in_ready), 32'd0);
        chk("basic_start", 32'(layer_start), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_vec", vec_out, 32'h007FFD05);
        tick();
        chk("basic_start_single", 32'(layer_start), 32'd0);
        chk("basic_busy_wait", 32'(busy), 32'd1);

        // wait and re-arm
        for (int c = 0; c < 20; c++) begin
            chk("wait_vec_stable", vec_out, 32'h007FFD05);
            chk("wait_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        chk("wait_cnt0", 32'(sample_cnt), 32'd0);
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("rearm_cnt", 32'(sample_cnt), 32'd1);
        chk("rearm_ready", 32'(in_ready), 32'd1);
        chk("rearm_busy", 32'(busy), 32'd0);

        // gapped input; last word is the most negative value
        send_word(8'd10);
        in_valid = 1'b0; in_data = 8'h55; tick();
        send_word(8'd20);
        in_valid = 1'b0; in_data = 8'h55; tick();
        send_word(8'hFF);
        in_valid = 1'b0; in_data = 8'h55; tick();
        chk("gap_no_start", 32'(layer_start), 32'd0);
        chk("gap_ready", 32'(in_ready), 32'd1);
        send_word(8'h80);
        in_valid = 1'b0;
        chk("gap_start", 32'(layer_start), 32'd1);
        chk("gap_vec_clamp", vec_out, {NEG_EXP, 24'hFF140A});
        tick();
        chk("gap_start_single", 32'(layer_start), 32'd0);
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("gap_cnt", 32'(sample_cnt), 32'd2);

        // flush with a concurrent third word
        send_word(8'h01);
        send_word(8'h02);
        in_valid = 1'b1; in_data = 8'h33; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_vec", vec_out, {NEG_EXP, 24'hFF0201});
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        chk("fresh_no_start", 32'(layer_start), 32'd0);
        send_word(8'h44);
        in_valid = 1'b0;
        chk("fresh_start", 32'(layer_start), 32'd1);
        chk("fresh_vec", vec_out, 32'h44332211);

        // done coincident with ST_FIRE is ignored
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        tick();
        chk("fire_done_busy", 32'(busy), 32'd1);
        chk("fire_done_cnt", 32'(sample_cnt), 32'd2);

        // flush beats layer_done in ST_WAIT
        flush = 1'b1; layer_done = 1'b1;
        tick();
        flush = 1'b0; layer_done = 1'b0;
        chk("wflush_busy", 32'(busy), 32'd0);
        chk("wflush_cnt", 32'(sample_cnt), 32'd2);
        chk("wflush_ready", 32'(in_ready), 32'd1);
        chk("wflush_vec", vec_out, 32'h44332211);

        // spurious done in ST_LOAD
        layer_done = 1'b1;
        tick(); tick(); tick();
        layer_done = 1'b0;
        chk("load_done_cnt", 32'(sample_cnt), 32'd2);
        chk("load_done_busy", 32'(busy), 32'd0);

        // counter wrap
        for (int s = 0; s < 253; s++) begin
            run_sample(8'(s));
        end
        chk("cnt_255", 32'(sample_cnt), 32'd255);
        run_sample(8'h60);
        chk("cnt_wrap", 32'(sample_cnt), 32'd0);
        chk("wrap_vec", vec_out, 32'h63626160);

        // async reset while waiting
        send_word(8'h0A);
        send_word(8'h0B);
        send_word(8'h0C);
        send_word(8'h0D);
        in_valid = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vec", vec_out, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt", 32'(sample_cnt), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_start", 32'(layer_start), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_rearm", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
